// File: rtl/tcp_vlg_app_tx_if.sv
// rtl/tcp_vlg_app_tx_if.sv - application/core byte handshake bundle for tcp_vlg_app_tx
interface tcp_vlg_app_tx_if #(
    parameter int DEPTH = 4
);
    logic             connected;
    logic [7:0]       usr_dat;
    logic             usr_val;
    logic             usr_rdy;
    logic [7:0]       core_dat;
    logic             core_val;
    logic             core_full;
    logic [DEPTH:0]   pending;
    logic [15:0]      drop_cnt;

    modport master (
        output connected, usr_dat, usr_val, core_full,
        input  usr_rdy, core_dat, core_val, pending, drop_cnt
    );

    modport slave (
        input  connected, usr_dat, usr_val, core_full,
        output usr_rdy, core_dat, core_val, pending, drop_cnt
    );
endinterface

// File: rtl/tcp_vlg_app_tx.sv
// rtl/tcp_vlg_app_tx.sv - application byte FIFO that batches user data into bursts toward the TCP core
module tcp_vlg_app_tx #(
    parameter int DEPTH       = 4,
    parameter int BURST_BYTES = 8,
    parameter int IDLE_TICKS  = 100
) (
    input  logic             clk,
    input  logic             rst,
    tcp_vlg_app_tx_if.slave  bus
);
    localparam int              ENTRIES = 2 ** DEPTH;
    localparam int              TW      = $clog2(IDLE_TICKS + 1);
    localparam logic [DEPTH:0]  C_FULL  = (DEPTH + 1)'(ENTRIES);
    localparam logic [DEPTH:0]  C_BURST = (DEPTH + 1)'(BURST_BYTES);
    localparam logic [TW-1:0]   C_TLAST = TW'(IDLE_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_BURST = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t           r_state;
    logic [7:0]       r_mem [ENTRIES];
    logic [DEPTH-1:0] r_wptr;
    logic [DEPTH-1:0] r_rptr;
    logic [DEPTH:0]   r_count;
    logic [TW-1:0]    r_timer;
    logic             r_core_val;
    logic [7:0]       r_core_dat;
    logic [15:0]      r_drop_cnt;

    logic             w_usr_rdy;
    logic             w_wr;
    logic             w_pop;
    logic             w_to_drop;
    logic [DEPTH:0]   w_cnt_next;

    // Ready is held low during reset so nothing is accepted before the FIFO is known-empty.
    assign w_usr_rdy  = !rst && bus.connected && (r_count != C_FULL) && (r_state != S_DROP);
    assign w_wr       = bus.usr_val && w_usr_rdy;
    // Pops stop as soon as the link drops so no byte leaks to the core on the way into DROP.
    assign w_pop      = (r_state == S_BURST) && bus.connected && (r_count != '0) && !bus.core_full;
    assign w_to_drop  = ((r_state == S_FILL) || (r_state == S_BURST)) && !bus.connected;
    assign w_cnt_next = r_count + {{DEPTH{1'b0}}, w_wr} - {{DEPTH{1'b0}}, w_pop};

    assign bus.usr_rdy  = w_usr_rdy;
    assign bus.core_val = r_core_val;
    assign bus.core_dat = r_core_dat;
    assign bus.pending  = r_count;
    assign bus.drop_cnt = r_drop_cnt;

    // Byte storage; contents need no reset because occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= bus.usr_dat;
        end
    end

    // Control FSM with FIFO pointers, idle timer, registered core output and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_timer    <= '0;
            r_core_val <= 1'b0;
            r_core_dat <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_core_val <= 1'b0;
            r_count    <= w_cnt_next;
            if (w_wr) begin
                r_wptr <= r_wptr + DEPTH'(1);
            end
            if (w_pop) begin
                r_rptr     <= r_rptr + DEPTH'(1);
                r_core_val <= 1'b1;
                r_core_dat <= r_mem[r_rptr];
            end
            if (w_to_drop && (r_count != '0) && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_wr) begin
                        r_state <= S_FILL;
                        r_timer <= '0;
                    end
                end
                S_FILL: begin
                    if (!bus.connected) begin
                        r_state <= S_DROP;
                    end else begin
                        if (w_wr) begin
                            r_timer <= '0;
                        end else if (r_timer != {TW{1'b1}}) begin
                            r_timer <= r_timer + TW'(1);
                        end
                        if ((w_cnt_next >= C_BURST) || (!w_wr && (r_timer >= C_TLAST))) begin
                            r_state <= S_BURST;
                        end
                    end
                end
                S_BURST: begin
                    if (!bus.connected) begin
                        r_state <= S_DROP;
                    end else if (w_pop && (w_cnt_next == '0)) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DROP: begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                    r_timer <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tcp_vlg_app_tx.sv
// tb/tb_tcp_vlg_app_tx.sv - directed self-checking bench for tcp_vlg_app_tx
module tb_tcp_vlg_app_tx;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] rx_q[$];

    tcp_vlg_app_tx_if #(.DEPTH(4)) bus ();

    tcp_vlg_app_tx #(
        .DEPTH(4),
        .BURST_BYTES(8),
        .IDLE_TICKS(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect every byte handed to the core.
    always @(negedge clk) begin
        if (bus.core_val) rx_q.push_back(bus.core_dat);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            check("wr_rdy", bus.usr_rdy, 1);
            bus.usr_val = 1'b1;
            bus.usr_dat = first + 8'(i);
            step();
        end
        bus.usr_val = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((bus.pending != 0 || bus.core_val) && n < 60) begin
            step();
            n++;
        end
        check({tag, "_drain_in_time"}, (n < 60), 1);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] first, input int n);
        check({tag, "_rx_count"}, rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_rx_byte"}, (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD, first + 8'(i));
        end
    endtask

    task automatic do_drop();
        push_bytes(8'hA0, 1);
        bus.connected = 1'b0;
        step();
        bus.connected = 1'b1;
        step();
    endtask

    initial begin
        int n_hi;
        rst           = 1'b1;
        bus.connected = 1'b1;
        bus.usr_dat   = 8'h00;
        bus.usr_val   = 1'b0;
        bus.core_full = 1'b0;
        step();
        step();
        check("rst_usr_rdy", bus.usr_rdy, 0);
        check("rst_core_val", bus.core_val, 0);
        check("rst_pending", bus.pending, 0);
        check("rst_drop_cnt", bus.drop_cnt, 0);
        rst = 1'b0;
        step();
        check("post_rst_rdy", bus.usr_rdy, 1);

        // Eight back-to-back bytes reach the burst threshold and stream out in order.
        push_bytes(8'h01, 8);
        check("t1_pending8", bus.pending, 8);
        check("t1_cv_before", bus.core_val, 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("t1_core_val", bus.core_val, 1);
            check("t1_core_dat", bus.core_dat, k);
            check("t1_pending", bus.pending, 8 - k);
        end
        step();
        check("t1_cv_after", bus.core_val, 0);
        check("t1_pending_end", bus.pending, 0);

        // Three bytes then silence: burst after 100 idle cycles.
        push_bytes(8'h11, 3);
        n_hi = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (bus.core_val) n_hi++;
        end
        check("t2_no_early_burst", n_hi, 0);
        check("t2_pending_wait", bus.pending, 3);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t2_core_val", bus.core_val, 1);
            check("t2_core_dat", bus.core_dat, 8'h11 + k);
        end
        step();
        check("t2_cv_after", bus.core_val, 0);
        check("t2_pending_end", bus.pending, 0);

        // Back-pressure mid-burst: no loss, no duplication.
        rx_q.delete();
        push_bytes(8'h21, 8);
        step();
        step();
        bus.core_full = 1'b1;
        n_hi = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus.core_val) n_hi++;
        end
        check("t3_full_at_most_one", (n_hi <= 1), 1);
        bus.core_full = 1'b0;
        drain("t3");
        check_rx("t3", 8'h21, 8);

        // Fill to 16 with core blocked; 17th byte refused; wrapped pointers drain in order.
        rx_q.delete();
        bus.core_full = 1'b1;
        push_bytes(8'h31, 16);
        check("t4_pending16", bus.pending, 16);
        check("t4_full_rdy", bus.usr_rdy, 0);
        bus.usr_val = 1'b1;
        bus.usr_dat = 8'h99;
        step();
        check("t4_17th_refused", bus.pending, 16);
        bus.usr_val   = 1'b0;
        bus.core_full = 1'b0;
        drain("t4");
        check_rx("t4", 8'h31, 16);

        // Disconnect with 5 pending: one DROP cycle, counter bumps, nothing emitted.
        rx_q.delete();
        push_bytes(8'h51, 5);
        bus.connected = 1'b0;
        step();
        check("t5_drop_cnt", bus.drop_cnt, 1);
        bus.connected = 1'b1;
        #1;
        check("t5_rdy_in_drop", bus.usr_rdy, 0);
        step();
        check("t5_pending_clr", bus.pending, 0);
        check("t5_rdy_after", bus.usr_rdy, 1);
        check("t5_no_core_val", rx_q.size(), 0);
        bus.connected = 1'b0;
        #1;
        check("t5_idle_disc_rdy", bus.usr_rdy, 0);
        bus.usr_val = 1'b1;
        step();
        check("t5_idle_disc_nowr", bus.pending, 0);
        bus.usr_val   = 1'b0;
        bus.connected = 1'b1;
        step();

        // Counter saturation.
        force dut.r_drop_cnt = 16'hFFFE;
        step();
        release dut.r_drop_cnt;
        do_drop();
        check("t6_drop_ffff", bus.drop_cnt, 16'hFFFF);
        do_drop();
        check("t6_drop_sat", bus.drop_cnt, 16'hFFFF);

        // Reset mid-burst clears core_val at once and empties the FIFO.
        push_bytes(8'h61, 8);
        step();
        check("t7_cv_in_burst", bus.core_val, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t7_rst_cv", bus.core_val, 0);
        check("t7_rst_pending", bus.pending, 0);
        check("t7_rst_rdy", bus.usr_rdy, 0);
        check("t7_rst_drop_cnt", bus.drop_cnt, 0);
        rst = 1'b0;
        step();
        check("t7_post_cv", bus.core_val, 0);
        check("t7_post_rdy", bus.usr_rdy, 1);
        push_bytes(8'h71, 1);
        check("t7_post_write", bus.pending, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
